register_bank: RTL and testbench
================================

REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 Parameter WIDTH, default 8, data width of every register.
REQ-002 Parameter NUM_REGS, default 3 (A, X, Y), number of registers; legal range 2..16.
REQ-003 Parameter IDX_W, default $clog2(NUM_REGS), width of register select fields.
REQ-004 FSM_Signal  in  1  the single clock; all state updates on its rising edge.
REQ-005 reset_R  in  1  synchronous, active-high reset.
REQ-006 op_valid  in  1  command present this cycle.
REQ-007 op_ready  out  1  bank accepts a command this cycle.
REQ-008 op  in  3  opcode: NOP=0, LOAD=1, XFER=2, INC=3, DEC=4, CLR=5, SHL=6, SHR=7.
REQ-009 dst_sel  in  IDX_W  destination register index.
REQ-010 src_sel  in  IDX_W  source index for XFER and for OUT_SEL.
REQ-011 IN_D  in  WIDTH  load data for LOAD.
REQ-012 OUT_REGS  out  NUM_REGS*WIDTH  all registers, register i at bits [i*WIDTH +: WIDTH].
REQ-013 OUT_SEL  out  WIDTH  combinational read of register src_sel; 0 if src_sel is out of range.
REQ-014 done  out  1  one-cycle pulse, the cycle after an executed op.
REQ-015 err  out  1  one-cycle pulse, the cycle after a rejected op.
REQ-016 flag_N, flag_Z, flag_C  out  1 each  registered status flags.

Function
REQ-017 A command is accepted on a rising edge when op_valid and op_ready are both high; its result is visible on OUT_REGS and the flags after that same edge.
REQ-018 LOAD writes IN_D to dst; XFER writes reg[src_sel] to dst; INC adds 1 modulo 2^WIDTH; DEC subtracts 1 modulo 2^WIDTH; CLR writes 0.
REQ-019 SHL shifts dst left and fills bit 0 with 0; SHR shifts dst right and fills the MSB with 0; flag_C takes the shifted-out bit.
REQ-020 Every executed op except NOP sets flag_N to the result MSB and flag_Z to (result == 0).
REQ-021 flag_C changes only on SHL and SHR.
REQ-022 NOP changes no register or flag; done still pulses.
REQ-023 If dst_sel >= NUM_REGS, or op is XFER and src_sel >= NUM_REGS, the op is rejected: no state changes, err pulses, done stays low.
REQ-024 XFER with src_sel == dst_sel leaves the register value unchanged but updates N and Z.
REQ-025 Wrap-around: INC of all-ones gives 0 with Z=1; DEC of 0 gives all-ones with N=1.
REQ-026 op_ready is registered: low in the cycle after any cycle with reset_R high, high otherwise.
REQ-027 When op_valid is high and op_ready is low, no state changes and neither done nor err pulses.

Reset
REQ-028 A cycle with reset_R high clears all registers, flag_N, flag_Z, flag_C, done and err to 0, and sets op_ready to 0 for the next cycle.
REQ-029 Reset takes priority over a simultaneous accepted command; that command is discarded with no done or err pulse.

Configuration
REQ-030 Macro REGISTER_BANK_FLAGS_EN: when defined, flag logic per REQ-019 to REQ-021 and REQ-024 to REQ-025 is built.
REQ-031 When REGISTER_BANK_FLAGS_EN is undefined, flag_N, flag_Z and flag_C are tied to 0 and no flag flops are built; all register behaviour is unchanged.

Structure
REQ-032 Package register_bank_pkg holds the opcode enum (op_e), the flag struct (flags_t: n, z, c) and the opcode-width constant.
REQ-033 Sub-module register_bank_alu is purely combinational: inputs op, operand and IN_D; outputs result and carry.

Verification
REQ-034 Reset, then LOAD reg0 = 8'h80 -> OUT_REGS[7:0] = 8'h80, N=1, Z=0, done pulses for one cycle.
REQ-035 LOAD reg1 = 8'hFF, then INC reg1 -> reg1 = 8'h00, Z=1, N=0, C unchanged.
REQ-036 LOAD reg2 = 8'h81, then SHL reg2 -> 8'h02, C=1; then SHR reg2 -> 8'h01, C=0.
REQ-037 XFER with src=0 (8'h80) and dst=2 -> reg2 = 8'h80; then XFER with dst=3 (NUM_REGS=3) -> err pulses and no register changes.
REQ-038 Assert reset_R in the same cycle as a valid LOAD of 8'h55 -> all registers 0, no done, op_ready low for the next cycle, LOAD accepted the cycle after that.
REQ-039 Repeat REQ-034 to REQ-036 with REGISTER_BANK_FLAGS_EN undefined and WIDTH=16 -> identical register values, all flags constantly 0.

Source files
------------

// File: rtl/register_bank_pkg.sv
// Shared opcode, flag and width definitions for the register bank.
package register_bank_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 3'd0,
    OP_LOAD = 3'd1,
    OP_XFER = 3'd2,
    OP_INC  = 3'd3,
    OP_DEC  = 3'd4,
    OP_CLR  = 3'd5,
    OP_SHL  = 3'd6,
    OP_SHR  = 3'd7
  } op_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
  } flags_t;

endpackage

// File: rtl/register_bank_alu.sv
// Combinational datapath: computes the new register value and shift carry.
module register_bank_alu
  import register_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] operand,
  input  logic [WIDTH-1:0] IN_D,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  always_comb begin
    result = operand;
    carry  = 1'b0;
    case (op)
      OP_LOAD: result = IN_D;
      OP_XFER: result = operand;
      OP_INC:  result = operand + WIDTH'(1);
      OP_DEC:  result = operand - WIDTH'(1);
      OP_CLR:  result = '0;
      OP_SHL: begin
        result = {operand[WIDTH-2:0], 1'b0};
        carry  = operand[WIDTH-1];
      end
      OP_SHR: begin
        result = {1'b0, operand[WIDTH-1:1]};
        carry  = operand[0];
      end
      default: result = operand;
    endcase
  end

endmodule

// File: rtl/register_bank.sv
// Small register bank executing one op per accepted command.
// REGISTER_BANK_FLAGS_EN builds the N/Z/C status flags; otherwise they read 0.
module register_bank
  import register_bank_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 3,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                      FSM_Signal,
  input  logic                      reset_R,
  input  logic                      op_valid,
  output logic                      op_ready,
  input  logic [OP_W-1:0]           op,
  input  logic [IDX_W-1:0]          dst_sel,
  input  logic [IDX_W-1:0]          src_sel,
  input  logic [WIDTH-1:0]          IN_D,
  output logic [NUM_REGS*WIDTH-1:0] OUT_REGS,
  output logic [WIDTH-1:0]          OUT_SEL,
  output logic                      done,
  output logic                      err,
  output logic                      flag_N,
  output logic                      flag_Z,
  output logic                      flag_C
);

  logic [NUM_REGS-1:0][WIDTH-1:0] regs;
  op_e              opc;
  logic             dst_ok, src_ok, accept, reject, exec;
  logic [WIDTH-1:0] operand, result;
  logic             carry;

  assign opc    = op_e'(op);
  assign dst_ok = int'(dst_sel) < NUM_REGS;
  assign src_ok = int'(src_sel) < NUM_REGS;
  assign accept = op_valid && op_ready;
  assign reject = accept && (!dst_ok || (opc == OP_XFER && !src_ok));
  assign exec   = accept && !reject;

  // XFER reads the source register; every other op works on the destination.
  always_comb begin
    operand = '0;
    if (opc == OP_XFER) begin
      if (src_ok) operand = regs[src_sel];
    end else if (dst_ok) begin
      operand = regs[dst_sel];
    end
  end

  assign OUT_SEL  = src_ok ? regs[src_sel] : '0;
  assign OUT_REGS = regs;

  register_bank_alu #(.WIDTH(WIDTH)) u_alu (
    .op      (opc),
    .operand (operand),
    .IN_D    (IN_D),
    .result  (result),
    .carry   (carry)
  );

  always_ff @(posedge FSM_Signal) begin
    if (reset_R) begin
      regs     <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      op_ready <= 1'b0;
    end else begin
      op_ready <= 1'b1;
      done     <= exec;
      err      <= reject;
      if (exec && opc != OP_NOP) regs[dst_sel] <= result;
    end
  end

`ifdef REGISTER_BANK_FLAGS_EN
  flags_t flags;

  always_ff @(posedge FSM_Signal) begin
    if (reset_R) begin
      flags <= '0;
    end else if (exec && opc != OP_NOP) begin
      flags.n <= result[WIDTH-1];
      flags.z <= (result == '0);
      if (opc == OP_SHL || opc == OP_SHR) flags.c <= carry;
    end
  end

  assign flag_N = flags.n;
  assign flag_Z = flags.z;
  assign flag_C = flags.c;
`else
  logic unused_carry;
  assign unused_carry = carry;
  assign flag_N = 1'b0;
  assign flag_Z = 1'b0;
  assign flag_C = 1'b0;
`endif

endmodule

// File: tb/tb_register_bank.sv
// Directed-vector bench for register_bank (WIDTH=8, NUM_REGS=3).
module tb_register_bank;
  import register_bank_pkg::*;

  localparam int WIDTH = 8;
  localparam int NREG  = 3;
  localparam int IDX_W = 2;
`ifdef REGISTER_BANK_FLAGS_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  op_valid;
  logic                  op_ready;
  logic [OP_W-1:0]       op;
  logic [IDX_W-1:0]      dst_sel, src_sel;
  logic [WIDTH-1:0]      in_d;
  logic [NREG*WIDTH-1:0] out_regs;
  logic [WIDTH-1:0]      out_sel;
  logic                  done, err, fn, fz, fc;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  register_bank #(.WIDTH(WIDTH), .NUM_REGS(NREG)) dut (
    .FSM_Signal (clk),
    .reset_R    (rst),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op         (op),
    .dst_sel    (dst_sel),
    .src_sel    (src_sel),
    .IN_D       (in_d),
    .OUT_REGS   (out_regs),
    .OUT_SEL    (out_sel),
    .done       (done),
    .err        (err),
    .flag_N     (fn),
    .flag_Z     (fz),
    .flag_C     (fc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expected flags collapse to 0 when the flag logic is not built.
  task automatic chk_state(input string tag, input logic [23:0] r,
                           input bit n, input bit z, input bit c,
                           input bit d, input bit e);
    chk({tag, ".regs"}, 32'(out_regs), 32'(r));
    chk({tag, ".N"},    32'(fn),   32'(FE & n));
    chk({tag, ".Z"},    32'(fz),   32'(FE & z));
    chk({tag, ".C"},    32'(fc),   32'(FE & c));
    chk({tag, ".done"}, 32'(done), 32'(d));
    chk({tag, ".err"},  32'(err),  32'(e));
  endtask

  task automatic issue(input op_e o, input logic [IDX_W-1:0] d, input logic [IDX_W-1:0] s,
                       input logic [WIDTH-1:0] v);
    op_valid = 1'b1; op = o; dst_sel = d; src_sel = s; in_d = v;
    cyc();
    op_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; op = OP_NOP; dst_sel = '0; src_sel = '0; in_d = '0;
    cyc(); cyc();
    chk_state("reset", 24'h000000, 0, 0, 0, 0, 0);
    chk("reset.ready", 32'(op_ready), 32'd0);
    rst = 1'b0;
    cyc();
    chk("ready_up", 32'(op_ready), 32'd1);

    issue(OP_LOAD, 2'd0, 2'd0, 8'h80); chk_state("load_r0", 24'h000080, 1, 0, 0, 1, 0);
    cyc();                             chk("done_pulse", 32'(done), 32'd0);
    issue(OP_LOAD, 2'd1, 2'd0, 8'hFF); chk_state("load_r1", 24'h00FF80, 1, 0, 0, 1, 0);
    issue(OP_LOAD, 2'd2, 2'd0, 8'h81); chk_state("load_r2", 24'h81FF80, 1, 0, 0, 1, 0);
    issue(OP_SHL,  2'd2, 2'd0, 8'h00); chk_state("shl_r2",  24'h02FF80, 0, 0, 1, 1, 0);
    issue(OP_INC,  2'd1, 2'd0, 8'h00); chk_state("inc_wrap", 24'h020080, 0, 1, 1, 1, 0);
    issue(OP_SHR,  2'd2, 2'd0, 8'h00); chk_state("shr_r2",  24'h010080, 0, 0, 0, 1, 0);
    issue(OP_DEC,  2'd1, 2'd0, 8'h00); chk_state("dec_wrap", 24'h01FF80, 1, 0, 0, 1, 0);
    issue(OP_XFER, 2'd2, 2'd0, 8'h00); chk_state("xfer_0_2", 24'h80FF80, 1, 0, 0, 1, 0);
    issue(OP_XFER, 2'd3, 2'd0, 8'h00); chk_state("bad_dst", 24'h80FF80, 1, 0, 0, 0, 1);
    cyc();                             chk("err_pulse", 32'(err), 32'd0);
    issue(OP_XFER, 2'd0, 2'd3, 8'h00); chk_state("bad_src", 24'h80FF80, 1, 0, 0, 0, 1);
    issue(OP_CLR,  2'd0, 2'd0, 8'h00); chk_state("clr_r0",  24'h80FF00, 0, 1, 0, 1, 0);
    issue(OP_XFER, 2'd1, 2'd1, 8'h00); chk_state("xfer_self", 24'h80FF00, 1, 0, 0, 1, 0);
    issue(OP_NOP,  2'd0, 2'd0, 8'h00); chk_state("nop",     24'h80FF00, 1, 0, 0, 1, 0);

    src_sel = 2'd2; #1; chk("out_sel_r2", 32'(out_sel), 32'h80);
    src_sel = 2'd1; #1; chk("out_sel_r1", 32'(out_sel), 32'hFF);
    src_sel = 2'd3; #1; chk("out_sel_oor", 32'(out_sel), 32'h00);

    // Reset beats a simultaneous command; the held command waits out op_ready low.
    rst = 1'b1; op_valid = 1'b1; op = OP_LOAD; dst_sel = 2'd0; in_d = 8'h55;
    cyc();
    chk_state("rst_vs_load", 24'h000000, 0, 0, 0, 0, 0);
    chk("rst_vs_load.ready", 32'(op_ready), 32'd0);
    rst = 1'b0;
    cyc();
    chk_state("not_ready", 24'h000000, 0, 0, 0, 0, 0);
    chk("not_ready.ready", 32'(op_ready), 32'd1);
    cyc();
    op_valid = 1'b0;
    chk_state("load_after_rst", 24'h000055, 0, 0, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
